usb_pkt_router: RTL and testbench

- Parametrised successor to the single-channel USB3 cache/decoder; sits between the USB3 slave-FIFO read logic and the per-channel DA waveform RAMs.
- Hunts for framed command packets in the 32-bit USB word stream and decodes a header plus length word.
- Routes each payload word to one of NUM_CH channel RAMs as a one-hot write enable, with an address counter and registered data.
- Adds variable packet length, channel-id range checking, an inter-word watchdog, and a soft-reset request output; the block never resets itself.

---
 rtl/usb_pkt_pkg.sv | 28 ++
 rtl/usb_pkt_watchdog.sv | 56 +++++
 rtl/usb_pkt_router.sv | 197 +++++++++++++++++++
 tb/tb_usb_pkt_router.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkt_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkt_pkg
//   Shared definitions for the USB3 packet router: framing constants,
//   command opcodes, the decoder state encoding and a header-detect helper.
// ---------------------------------------------------------------------------
package usb_pkt_pkg;

  // Framing bytes: a header word is FF_xx_xx_AA.
  localparam logic [7:0] SYNC_HI = 8'hFF;
  localparam logic [7:0] SYNC_LO = 8'hAA;

  // Command opcodes carried in header bits [23:16].
  localparam logic [7:0] OP_CHWR = 8'h01;
  localparam logic [7:0] OP_SRST = 8'h0A;

  // Decoder states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // True when the word carries both sync bytes in their framing positions.
  function automatic logic is_header(input logic [31:0] word);
    return (word[31:24] == SYNC_HI) && (word[7:0] == SYNC_LO);
  endfunction

endpackage

// File: rtl/usb_pkt_watchdog.sv
// ---------------------------------------------------------------------------
// usb_pkt_watchdog
//   Inter-word idle timer. While enabled, counts wrclock cycles without a
//   kick; flags expiry on the cycle whose idle clock would bring the count to
//   TIMEOUT_CYC. A kick in that same cycle wins and clears the count.
//
// Ports:
//   wrclock   in  clock
//   rst_n     in  asynchronous active-low reset
//   enable_i  in  timer runs only while high; cleared while low
//   kick_i    in  accepted word this cycle; clears the count
//   expire_o  out one-cycle expiry strobe (combinational from the count,
//                 the consumer registers it)
// ---------------------------------------------------------------------------
module usb_pkt_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic wrclock,
  input  logic rst_n,
  input  logic enable_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Count value reached after TIMEOUT_CYC-1 idle cycles; the next idle cycle
  // is the expiry cycle.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next idle count: clear when disabled or kicked, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || kick_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Idle counter register.
  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = enable_i && !kick_i && (cnt_q == LIMIT);

endmodule

// File: rtl/usb_pkt_router.sv
// ---------------------------------------------------------------------------
// usb_pkt_router
//   Hunts for framed command packets in the USB3 slave-FIFO word stream and
//   routes payload words to one of NUM_CH channel RAMs.
//
//   Packet: header FF_op_arg_AA, then a length word (L in [15:0]), then L
//   payload words. OP_CHWR writes channel 'arg'; OP_SRST requests a soft
//   reset from the surrounding system (this block never resets itself).
//
// Ports:
//   wrclock       in  sole clock
//   rst_n         in  asynchronous active-low reset
//   in_valid      in  in_data valid; no backpressure, every word consumed
//   in_data       in  32-bit USB word
//   ch_we         out one-hot channel write enable (registered)
//   ch_addr       out channel RAM write address (registered, holds)
//   ch_data       out channel RAM write data (registered, holds)
//   busy          out in the length or payload phase of a packet
//   pkt_done      out pulse alongside the last payload write
//   err           out pulse on rejected header/length or inter-word timeout
//   soft_rst_req  out pulse on a soft-reset command
// ---------------------------------------------------------------------------
module usb_pkt_router
  import usb_pkt_pkg::*;
#(
  parameter int unsigned NUM_CH      = 24,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              wrclock,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic [NUM_CH-1:0] ch_we,
  output logic [ADDR_W-1:0] ch_addr,
  output logic [31:0]       ch_data,
  output logic              busy,
  output logic              pkt_done,
  output logic              err,
  output logic              soft_rst_req
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned REM_W   = ADDR_W + 1;
  localparam int unsigned MAX_LEN = 32'd1 << ADDR_W;

  // Registered state and outputs.
  state_e              state_q;
  logic [CH_W-1:0]     cur_ch_q;
  logic [REM_W-1:0]    rem_q;
  logic [ADDR_W-1:0]   addr_cnt_q;
  logic [NUM_CH-1:0]   ch_we_q;
  logic [ADDR_W-1:0]   ch_addr_q;
  logic [31:0]         ch_data_q;
  logic                pkt_done_q;
  logic                err_q;
  logic                soft_rst_req_q;

  // Next-state helpers for the counters.
  logic [REM_W-1:0]    rem_d;
  logic [ADDR_W-1:0]   addr_d;

  // Decode of the incoming word.
  logic                hdr_s;
  logic [7:0]          op_s;
  logic [7:0]          arg_s;
  logic [15:0]         len_s;
  logic                ch_ok_s;
  logic                len_ok_s;
  logic                last_s;
  logic [NUM_CH-1:0]   ch_sel_s;
  logic                busy_s;
  logic                expire_s;

  // Header fields, range checks and counter arithmetic.
  always_comb begin
    hdr_s    = is_header(in_data);
    op_s     = in_data[23:16];
    arg_s    = in_data[15:8];
    len_s    = in_data[15:0];
    ch_ok_s  = (32'(arg_s) < NUM_CH);
    len_ok_s = (len_s != 16'd0) && (32'(len_s) <= MAX_LEN);
    // The remaining count still includes the word being written, so a value
    // of one marks the last payload word.
    last_s   = (rem_q == REM_W'(1));
    rem_d    = rem_q - REM_W'(1);
    addr_d   = addr_cnt_q + ADDR_W'(1);
  end

  // One-hot enable for the latched channel; cur_ch_q is range-checked on entry.
  always_comb begin
    ch_sel_s           = '0;
    ch_sel_s[cur_ch_q] = 1'b1;
  end

  assign busy_s = (state_q == ST_LEN) || (state_q == ST_DATA);

  usb_pkt_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .wrclock  (wrclock),
    .rst_n    (rst_n),
    .enable_i (busy_s),
    .kick_i   (in_valid),
    .expire_o (expire_s)
  );

  // Decode/route FSM with registered write port and status pulses.
  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cur_ch_q       <= '0;
      rem_q          <= '0;
      addr_cnt_q     <= '0;
      ch_we_q        <= '0;
      ch_addr_q      <= '0;
      ch_data_q      <= '0;
      pkt_done_q     <= 1'b0;
      err_q          <= 1'b0;
      soft_rst_req_q <= 1'b0;
    end else begin
      // Pulses default low; ch_addr/ch_data hold between writes.
      ch_we_q        <= '0;
      pkt_done_q     <= 1'b0;
      err_q          <= 1'b0;
      soft_rst_req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Non-header words are dropped silently while hunting.
          if (in_valid && hdr_s) begin
            case (op_s)
              OP_CHWR: begin
                if (ch_ok_s) begin
                  cur_ch_q <= arg_s[CH_W-1:0];
                  state_q  <= ST_LEN;
                end else begin
                  err_q <= 1'b1;
                end
              end
              OP_SRST: begin
                soft_rst_req_q <= 1'b1;
              end
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end
        end
        ST_LEN: begin
          // Any valid word is the length word, even one that looks like a header.
          if (in_valid) begin
            if (len_ok_s) begin
              rem_q      <= REM_W'(len_s);
              addr_cnt_q <= '0;
              state_q    <= ST_DATA;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (expire_s) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (in_valid) begin
            ch_we_q    <= ch_sel_s;
            ch_addr_q  <= addr_cnt_q;
            ch_data_q  <= in_data;
            addr_cnt_q <= addr_d;
            rem_q      <= rem_d;
            if (last_s) begin
              pkt_done_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end else if (expire_s) begin
            // Abort: words already written stay written, no pkt_done.
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ch_we        = ch_we_q;
  assign ch_addr      = ch_addr_q;
  assign ch_data      = ch_data_q;
  assign busy         = busy_s;
  assign pkt_done     = pkt_done_q;
  assign err          = err_q;
  assign soft_rst_req = soft_rst_req_q;

endmodule

// File: tb/tb_usb_pkt_router.sv
// ---------------------------------------------------------------------------
// tb_usb_pkt_router
//   Directed, self-checking bench for usb_pkt_router (NUM_CH=24, ADDR_W=8,
//   TIMEOUT_CYC=1024). Inputs change 1 time unit after a rising edge; outputs
//   are sampled at that same point, i.e. they reflect the word presented
//   before that edge.
// ---------------------------------------------------------------------------
module tb_usb_pkt_router;

  localparam int unsigned NUM_CH      = 24;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned TIMEOUT_CYC = 1024;

  logic              wrclock;
  logic              rst_n;
  logic              in_valid;
  logic [31:0]       in_data;
  logic [NUM_CH-1:0] ch_we;
  logic [ADDR_W-1:0] ch_addr;
  logic [31:0]       ch_data;
  logic              busy;
  logic              pkt_done;
  logic              err;
  logic              soft_rst_req;

  int tests;
  int fails;

  typedef struct packed {
    logic [23:0] we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        done;
    logic        err;
    logic        srst;
    logic        busy;
  } outs_t;

  typedef struct {
    logic        v;
    logic [31:0] d;
    outs_t       e;
  } vec_t;

  vec_t vecs[$];

  usb_pkt_router #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .wrclock      (wrclock),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .ch_we        (ch_we),
    .ch_addr      (ch_addr),
    .ch_data      (ch_data),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .err          (err),
    .soft_rst_req (soft_rst_req)
  );

  initial wrclock = 1'b0;
  always #5 wrclock = ~wrclock;

  function automatic outs_t mk(input logic [23:0] we, input logic [7:0] a,
                               input logic [31:0] d, input logic dn,
                               input logic er, input logic sr, input logic bz);
    outs_t o;
    o.we = we; o.addr = a; o.data = d; o.done = dn; o.err = er; o.srst = sr; o.busy = bz;
    return o;
  endfunction

  task automatic addv(input logic v, input logic [31:0] d, input logic [23:0] we,
                      input logic [7:0] a, input logic [31:0] dd, input logic dn,
                      input logic er, input logic sr, input logic bz);
    vec_t t;
    t.v = v; t.d = d; t.e = mk(we, a, dd, dn, er, sr, bz);
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge wrclock);
    #1;
  endtask

  task automatic check(input string nm, input outs_t exp);
    outs_t act;
    act.we = ch_we; act.addr = ch_addr; act.data = ch_data; act.done = pkt_done;
    act.err = err; act.srst = soft_rst_req; act.busy = busy;
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got we=%h addr=%h data=%h done=%b err=%b srst=%b busy=%b, expected we=%h addr=%h data=%h done=%b err=%b srst=%b busy=%b",
               nm, act.we, act.addr, act.data, act.done, act.err, act.srst, act.busy,
               exp.we, exp.addr, exp.data, exp.done, exp.err, exp.srst, exp.busy);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [7:0]  ea;
    logic [31:0] ed;
    logic [31:0] w;
    tests = 0;
    fails = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;

    // ---------------- vector table ----------------
    // Channel 5 write, three words back-to-back.
    addv(1'b1, 32'hFF0105AA, 24'h000000, 8'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'h00000003, 24'h000000, 8'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'h00000011, 24'h000020, 8'd0, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'h00000022, 24'h000020, 8'd1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'h00000033, 24'h000020, 8'd2, 32'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    // Header right after the last word; highest legal channel (23), length 1.
    addv(1'b1, 32'hFF0117AA, 24'h000000, 8'd2, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'h00000001, 24'h000000, 8'd2, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'hDEADBEEF, 24'h800000, 8'd0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    addv(1'b1, 32'hFF0A00AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    addv(1'b0, 32'h00000000, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    // Bad channel 32, then the would-be packet body is dropped.
    addv(1'b1, 32'hFF0120AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    addv(1'b1, 32'h00000003, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b1, 32'h000000AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    // Channel 24 is the first out-of-range value.
    addv(1'b1, 32'hFF0118AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    // Junk word dropped, then soft reset.
    addv(1'b1, 32'h12345678, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b1, 32'hFF0A00AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    addv(1'b0, 32'h00000000, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    // Wrong low sync byte: not a header.
    addv(1'b1, 32'hFF0105AB, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    // Unknown opcode.
    addv(1'b1, 32'hFF0700AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    // Length 0 rejected.
    addv(1'b1, 32'hFF0103AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'h00000000, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    // Header pattern in the length slot is a length (0x02AA, too long).
    addv(1'b1, 32'hFF0101AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'hFF0102AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    // Length 257 rejected, no writes.
    addv(1'b1, 32'hFF0100AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'h00000101, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    addv(1'b0, 32'h00000000, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    // Idle gaps in the length and data phases, channel 6.
    addv(1'b1, 32'hFF0106AA, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b0, 32'h00000000, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'h00000001, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b0, 32'h00000000, 24'h000000, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b1, 32'h0000CAFE, 24'h000040, 8'd0, 32'h0000CAFE, 1'b1, 1'b0, 1'b0, 1'b0);

    // ---------------- reset state ----------------
    repeat (3) @(posedge wrclock);
    #1;
    check("reset state", mk(24'h0, 8'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d);
      check($sformatf("vec %0d (%h)", i, vecs[i].d), vecs[i].e);
    end

    // ---------------- full-depth packet with gaps ----------------
    ea = 8'd0;
    ed = 32'h0000CAFE;
    drive(1'b1, 32'hFF0100AA);
    check("full hdr", mk(24'h0, ea, ed, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h00000100);
    check("full len", mk(24'h0, ea, ed, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 256; k++) begin
      int gaps;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        drive(1'b0, 32'h0);
        check($sformatf("full gap before %0d", k), mk(24'h0, ea, ed, 1'b0, 1'b0, 1'b0, 1'b1));
      end
      w = 32'hA5000000 | 32'(k);
      drive(1'b1, w);
      ea = 8'(k);
      ed = w;
      check($sformatf("full word %0d", k),
            mk(24'h000001, ea, ed, 1'(k == 255), 1'b0, 1'b0, 1'(k != 255)));
    end

    // ---------------- watchdog timeout ----------------
    drive(1'b1, 32'hFF0102AA);
    check("to hdr", mk(24'h0, ea, ed, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h00000004);
    check("to len", mk(24'h0, ea, ed, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h000000B0);
    check("to w0", mk(24'h000004, 8'd0, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h000000B1);
    check("to w1", mk(24'h000004, 8'd1, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 1; i <= 1030; i++) begin
      drive(1'b0, 32'h0);
      check($sformatf("to idle %0d", i),
            mk(24'h0, 8'd1, 32'hB1, 1'b0, 1'(i == 1024), 1'b0, 1'(i < 1024)));
    end
    drive(1'b1, 32'hFF0103AA);
    check("post-to hdr", mk(24'h0, 8'd1, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h00000001);
    check("post-to len", mk(24'h0, 8'd1, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h00000077);
    check("post-to word", mk(24'h000008, 8'd0, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0));

    // ---------------- async reset mid-payload ----------------
    drive(1'b1, 32'hFF0104AA);
    check("rst hdr", mk(24'h0, 8'd0, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h00000005);
    check("rst len", mk(24'h0, 8'd0, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h000000C0);
    check("rst w0", mk(24'h000010, 8'd0, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h000000C1);
    check("rst w1", mk(24'h000010, 8'd1, 32'hC1, 1'b0, 1'b0, 1'b0, 1'b1));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst immediate", mk(24'h0, 8'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge wrclock);
    @(negedge wrclock);
    rst_n = 1'b1;
    @(posedge wrclock);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h000000C2 + 32'(i));
      check($sformatf("rst leftover %0d", i), mk(24'h0, 8'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    drive(1'b1, 32'hFF0104AA);
    check("rst new hdr", mk(24'h0, 8'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h00000001);
    check("rst new len", mk(24'h0, 8'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h000000D0);
    check("rst new word", mk(24'h000010, 8'd0, 32'hD0, 1'b1, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 32'h0);
    check("rst new idle", mk(24'h0, 8'd0, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
